// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM states, fetch buffer entry layout, instruction size and the decode NOP.
package ifu_pkg;

  localparam int          INST_BYTES = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, FETCH, END, FAULT} ifu_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: instruction memory read port, redirect input and decode handshake.
// master = fetch unit side, slave = memory/decode/branch side.
interface instruction_fetch_unit_if;

  logic [63:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic        fetch_fault;

  modport master (
    output imem_addr, input imem_inst,
    input  redirect_valid, input redirect_pc,
    output id_valid, input id_ready, output id_inst, output id_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_addr, output imem_inst,
    output redirect_valid, output redirect_pc,
    input  id_valid, output id_ready, input id_inst, input id_pc,
    input  fetch_fault
  );

endinterface

// File: rtl/ifu_fifo.sv
// Sync FIFO of fetch entries; head is registered, visible the cycle after push.
// Flush beats push and pop; push into a full FIFO only succeeds alongside a pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_dat_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) count_d = count_q + (PTR_W+1)'(1);
      if (do_pop && !do_push) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count_q gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, reads imem combinationally, buffers {pc, inst} for decode.
// imem_addr -> id_valid takes 1 cycle; fetch stalls when the buffer is full and decode is not popping.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [63:0] IMEM_BYTES = 64'd16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  instruction_fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ifu_state_t       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic             push, pop, flush, in_range, redir_take;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  fetch_entry_t     head;

  // 65-bit compare so a PC near the top of the address space cannot wrap into range.
  assign in_range   = ({1'b0, pc_q} + 65'(INST_BYTES)) <= {1'b0, IMEM_BYTES};
  assign redir_take = bus.redirect_valid && (state_q == FETCH || state_q == END);
  assign pop        = bus.id_valid && bus.id_ready && !redir_take;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH, END: begin
        if (bus.redirect_valid) begin
          flush = 1'b1;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d    = bus.redirect_pc;
            state_d = FETCH;
          end
        end else if (state_q == FETCH) begin
          if (!in_range) begin
            state_d = END;
          end else if (fifo_count < CNT_W'(FIFO_DEPTH) || pop) begin
            push = 1'b1;
            pc_d = pc_q + 64'(INST_BYTES);
          end
        end
      end
      FAULT: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .flush_i    (flush),
    .push_i     (push),
    .push_dat_i ('{pc: pc_q, inst: bus.imem_inst}),
    .pop_i      (pop),
    .head_dat_o (head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = !fifo_empty;
  assign bus.id_inst     = fifo_empty ? NOP   : head.inst;
  assign bus.id_pc       = fifo_empty ? 64'h0 : head.pc;
  assign bus.fetch_fault = fault_q;

endmodule
